// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, serial-source select and default frame geometry.
// Used by both the transmitter and the receiver so the two ends agree on framing.
package uart_pkg;

    localparam int WORD_SIZE_DEF       = 8;
    localparam int SAMPLES_PER_BIT_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    typedef enum logic [2:0] {
        SER_ZERO = 3'd0,
        SER_ONE  = 3'd1,
        SER_LSB  = 3'd2,
        SER_NEXT = 3'd3,
        SER_PAR  = 3'd4
    } ser_src_e;

    // Counter width helper; a single-value counter still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_xmtr_datapath.sv
// UART transmitter datapath: shift register, sample/bit counters, registered serial line.
// Parity register exists only when UART_XMTR_PARITY_EN is defined.
module uart_xmtr_datapath
    import uart_pkg::*;
#(
    parameter int WORD_SIZE       = WORD_SIZE_DEF,
    parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
    input  logic                 Sample_clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] Data_Bus,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 clr_sample,
    input  logic                 inc_sample,
    input  logic                 inc_bit,
    input  logic                 ser_load,
    input  logic [2:0]           ser_src,
    output logic                 Serial_out,
    output logic                 sample_last,
    output logic                 bit_last
);

    localparam int SW = cnt_width(SAMPLES_PER_BIT);
    localparam int BW = cnt_width(WORD_SIZE + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WORD_SIZE - 1);

    logic [WORD_SIZE-1:0] XMT_shftreg;
    logic [SW-1:0]        Sample_counter;
    logic [BW-1:0]        Bit_counter;
    logic                 ser_next;

`ifdef UART_XMTR_PARITY_EN
    logic parity_reg;

    always_ff @(posedge Sample_clk) begin
        if (rst)
            parity_reg <= 1'b0;
        else if (load)
            parity_reg <= ^Data_Bus;
    end
`endif

    // SER_NEXT is taken on the shift edge, so it selects the bit about to become the LSB.
    always_comb begin
        ser_next = 1'b1;
        case (ser_src_e'(ser_src))
            SER_ZERO: ser_next = 1'b0;
            SER_LSB:  ser_next = XMT_shftreg[0];
            SER_NEXT: ser_next = XMT_shftreg[1];
`ifdef UART_XMTR_PARITY_EN
            SER_PAR:  ser_next = parity_reg;
`endif
            default:  ser_next = 1'b1;
        endcase
    end

    always_ff @(posedge Sample_clk) begin
        if (rst) begin
            XMT_shftreg    <= '0;
            Sample_counter <= '0;
            Bit_counter    <= '0;
            Serial_out     <= 1'b1;
        end else begin
            if (load)
                XMT_shftreg <= Data_Bus;
            else if (shift)
                XMT_shftreg <= {1'b0, XMT_shftreg[WORD_SIZE-1:1]};

            if (load || clr_sample)
                Sample_counter <= '0;
            else if (inc_sample)
                Sample_counter <= Sample_counter + 1'b1;

            if (load)
                Bit_counter <= '0;
            else if (inc_bit)
                Bit_counter <= Bit_counter + 1'b1;

            if (ser_load)
                Serial_out <= ser_next;
        end
    end

    assign sample_last = (Sample_counter == SAMPLE_LAST);
    assign bit_last    = (Bit_counter == BIT_LAST);

endmodule

// File: rtl/uart_xmtr.sv
// UART transmitter top: control FSM driving the datapath strobes; start 0, data LSB first, stop 1.
// Define UART_XMTR_PARITY_EN to insert an even-parity bit between data and stop.
//
//   state  | meaning
//   IDLE   | line high, waiting for Byte_ready
//   START  | sending start bit (0)
//   DATA   | sending data bits, LSB first
//   PARITY | sending even parity (UART_XMTR_PARITY_EN only)
//   STOP   | sending stop bit (1); XMT_done pulses on exit
module uart_xmtr
    import uart_pkg::*;
#(
    parameter int WORD_SIZE       = WORD_SIZE_DEF,
    parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
    input  logic                 Sample_clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] Data_Bus,
    input  logic                 Byte_ready,
    output logic                 Serial_out,
    output logic                 XMT_busy,
    output logic                 XMT_done
);

    uart_state_e state;
    logic        load, shift, clr_sample, inc_sample, inc_bit, ser_load;
    ser_src_e    ser_src;
    logic        sample_last, bit_last;

    always_comb begin
        load       = 1'b0;
        shift      = 1'b0;
        clr_sample = 1'b0;
        inc_sample = 1'b0;
        inc_bit    = 1'b0;
        ser_load   = 1'b0;
        ser_src    = SER_ONE;
        case (state)
            IDLE: begin
                if (Byte_ready) begin
                    load     = 1'b1;
                    ser_load = 1'b1;
                    ser_src  = SER_ZERO;
                end
            end
            START: begin
                if (sample_last) begin
                    clr_sample = 1'b1;
                    ser_load   = 1'b1;
                    ser_src    = SER_LSB;
                end else begin
                    inc_sample = 1'b1;
                end
            end
            DATA: begin
                if (sample_last) begin
                    shift      = 1'b1;
                    inc_bit    = 1'b1;
                    clr_sample = 1'b1;
                    ser_load   = 1'b1;
`ifdef UART_XMTR_PARITY_EN
                    ser_src    = bit_last ? SER_PAR : SER_NEXT;
`else
                    ser_src    = bit_last ? SER_ONE : SER_NEXT;
`endif
                end else begin
                    inc_sample = 1'b1;
                end
            end
`ifdef UART_XMTR_PARITY_EN
            PARITY: begin
                if (sample_last) begin
                    clr_sample = 1'b1;
                    ser_load   = 1'b1;
                    ser_src    = SER_ONE;
                end else begin
                    inc_sample = 1'b1;
                end
            end
`endif
            STOP: begin
                if (sample_last) begin
                    clr_sample = 1'b1;
                    ser_load   = 1'b1;
                    ser_src    = SER_ONE;
                end else begin
                    inc_sample = 1'b1;
                end
            end
            // Unused encodings force the line back to idle-high.
            default: begin
                ser_load = 1'b1;
                ser_src  = SER_ONE;
            end
        endcase
    end

    always_ff @(posedge Sample_clk) begin
        if (rst) begin
            state    <= IDLE;
            XMT_busy <= 1'b0;
            XMT_done <= 1'b0;
        end else begin
            XMT_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Byte_ready) begin
                        state    <= START;
                        XMT_busy <= 1'b1;
                    end
                end
                START: begin
                    if (sample_last)
                        state <= DATA;
                end
                DATA: begin
                    if (sample_last && bit_last)
`ifdef UART_XMTR_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                end
`ifdef UART_XMTR_PARITY_EN
                PARITY: begin
                    if (sample_last)
                        state <= STOP;
                end
`endif
                STOP: begin
                    if (sample_last) begin
                        state    <= IDLE;
                        XMT_busy <= 1'b0;
                        XMT_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    XMT_busy <= 1'b0;
                end
            endcase
        end
    end

    uart_xmtr_datapath #(
        .WORD_SIZE       (WORD_SIZE),
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_datapath (
        .Sample_clk  (Sample_clk),
        .rst         (rst),
        .Data_Bus    (Data_Bus),
        .load        (load),
        .shift       (shift),
        .clr_sample  (clr_sample),
        .inc_sample  (inc_sample),
        .inc_bit     (inc_bit),
        .ser_load    (ser_load),
        .ser_src     (ser_src),
        .Serial_out  (Serial_out),
        .sample_last (sample_last),
        .bit_last    (bit_last)
    );

endmodule

// File: tb/tb_uart_xmtr.sv
// Self-checking bench for uart_xmtr: a line monitor decodes every frame and compares it with
// an expected-frame queue filled as requests are driven. Honours UART_XMTR_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_xmtr;
    import uart_pkg::*;

    localparam int WS  = 8;
    localparam int SPB = 8;
`ifdef UART_XMTR_PARITY_EN
    localparam int NB = WS + 3;
`else
    localparam int NB = WS + 2;
`endif
    localparam int FRAME = NB * SPB;

    logic          Sample_clk = 1'b0;
    logic          rst;
    logic          Byte_ready;
    logic [WS-1:0] Data_Bus;
    logic          Serial_out, XMT_busy, XMT_done;

    uart_xmtr #(.WORD_SIZE(WS), .SAMPLES_PER_BIT(SPB)) dut (
        .Sample_clk (Sample_clk),
        .rst        (rst),
        .Data_Bus   (Data_Bus),
        .Byte_ready (Byte_ready),
        .Serial_out (Serial_out),
        .XMT_busy   (XMT_busy),
        .XMT_done   (XMT_done)
    );

    always #5 Sample_clk = ~Sample_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line pattern, index 0 = first bit on the wire.
    function automatic logic [NB-1:0] model(input logic [WS-1:0] d, input logic p);
`ifdef UART_XMTR_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, d, 1'b0} | {NB{p & 1'b0}};
`endif
    endfunction

    logic [NB-1:0] exp_q[$];

    // Line monitor: every bit must be stable for SPB samples, busy high, done low,
    // then done/busy/line checked on the sample after the final stop-bit cycle.
    int            cyc = 0, n = 0;
    int            frames_started = 0, frames_done = 0, done_cnt = 0;
    int            start_cyc = 0, prev_start = 0;
    logic          in_frame = 1'b0;
    logic          shape_ok = 1'b1;
    logic [NB-1:0] bits = '0;

    always @(negedge Sample_clk) begin
        cyc++;
        if (XMT_done === 1'b1) done_cnt++;
        if (rst !== 1'b0) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && Serial_out === 1'b0) begin
                in_frame   = 1'b1;
                n          = 0;
                shape_ok   = 1'b1;
                bits       = '0;
                prev_start = start_cyc;
                start_cyc  = cyc;
                frames_started++;
            end
            if (in_frame) begin
                if (n < FRAME) begin
                    if (n % SPB == 0) bits[n / SPB] = Serial_out;
                    else if (Serial_out !== bits[n / SPB]) shape_ok = 1'b0;
                    if (XMT_busy !== 1'b1 || XMT_done !== 1'b0) shape_ok = 1'b0;
                    n++;
                end else begin
                    check("frame_shape", 32'(shape_ok), 32'd1);
                    check("done_at_end", 32'({XMT_done, XMT_busy, Serial_out}), 32'h5);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", bits);
                    end else begin
                        check("frame_bits", 32'(bits), 32'(exp_q.pop_front()));
                    end
                    in_frame = 1'b0;
                    frames_done++;
                end
            end
        end
    end

    task automatic send(input logic [WS-1:0] d, input logic p);
        @(negedge Sample_clk);
        Data_Bus   = d;
        Byte_ready = 1'b1;
        exp_q.push_back(model(d, p));
        @(negedge Sample_clk);
        Byte_ready = 1'b0;
        Data_Bus   = ~d;
    endtask

    task automatic wait_frames(input int target, input string name);
        int t = 0;
        while (frames_done < target && t < 4 * FRAME) begin
            @(negedge Sample_clk);
            t++;
        end
        check(name, 32'(frames_done >= target), 32'd1);
    endtask

    typedef struct {
        logic [WS-1:0] data;
        logic          par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, s0, t;
        logic line_ok;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h96, 1'b0};
        vecs[4] = '{8'h07, 1'b1};
        vecs[5] = '{8'h01, 1'b1};

        rst        = 1'b1;
        Byte_ready = 1'b0;
        Data_Bus   = '0;
        repeat (2) @(negedge Sample_clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge Sample_clk);
            check("idle_after_reset", 32'({Serial_out, XMT_busy, XMT_done}), 32'h4);
        end

        for (int i = 0; i < 6; i++) begin
            f0 = frames_done;
            d0 = done_cnt;
            send(vecs[i].data, vecs[i].par);
            wait_frames(f0 + 1, "single_frame_timeout");
            check("single_done_count", 32'(done_cnt - d0), 32'd1);
            repeat (3) @(negedge Sample_clk);
        end

        // Back-to-back with Byte_ready held high.
        f0 = frames_done;
        d0 = done_cnt;
        s0 = frames_started;
        @(negedge Sample_clk);
        Data_Bus   = 8'h3C;
        Byte_ready = 1'b1;
        exp_q.push_back(model(8'h3C, 1'b0));
        @(negedge Sample_clk);
        Data_Bus = 8'hC3;
        exp_q.push_back(model(8'hC3, 1'b0));
        t = 0;
        while (frames_started < s0 + 2 && t < 4 * FRAME) begin
            @(negedge Sample_clk);
            t++;
        end
        Byte_ready = 1'b0;
        check("b2b_second_start", 32'(frames_started >= s0 + 2), 32'd1);
        check("b2b_start_spacing", 32'(start_cyc - prev_start), 32'(FRAME + 1));
        wait_frames(f0 + 2, "b2b_timeout");
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        repeat (FRAME) @(negedge Sample_clk);
        check("b2b_no_third_frame", 32'(frames_started - s0), 32'd2);

        // Request while busy is ignored.
        f0 = frames_done;
        d0 = done_cnt;
        s0 = frames_started;
        send(8'h55, 1'b0);
        repeat (29) @(negedge Sample_clk);
        Data_Bus   = 8'hFF;
        Byte_ready = 1'b1;
        @(negedge Sample_clk);
        Byte_ready = 1'b0;
        wait_frames(f0 + 1, "busy_ignore_timeout");
        repeat (FRAME) @(negedge Sample_clk);
        check("busy_ignore_frames", 32'(frames_started - s0), 32'd1);
        check("busy_ignore_done", 32'(done_cnt - d0), 32'd1);

        // Reset mid-frame.
        d0 = done_cnt;
        send(8'hA5, 1'b0);
        repeat (39) @(negedge Sample_clk);
        rst = 1'b1;
        @(negedge Sample_clk);
        check("abort_line_busy", 32'({Serial_out, XMT_busy, XMT_done}), 32'h4);
        rst = 1'b0;
        exp_q.delete();
        line_ok = 1'b1;
        repeat (FRAME + 10) begin
            @(negedge Sample_clk);
            if (Serial_out !== 1'b1 || XMT_busy !== 1'b0) line_ok = 1'b0;
        end
        check("abort_line_stays_idle", 32'(line_ok), 32'd1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        f0 = frames_done;
        send(8'h5A, 1'b0);
        wait_frames(f0 + 1, "post_abort_timeout");
        check("post_abort_done", 32'(done_cnt - d0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
